// File: rtl/in_sync_pulse.sv
// Debounced input conditioner: per-channel 2-flop sync, stability counter, rise/fall pulses.
// Optional auto-repeat of rise while held, enabled by defining HOLD_REPEAT_EN.

module in_sync_pulse_ch #(
  parameter int DB_CNT     = 4
`ifdef HOLD_REPEAT_EN
  ,
  parameter int REP_DELAY  = 50,
  parameter int REP_PERIOD = 10
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          acc_rise;

  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    acc_rise = 1'b0;
    fall_d   = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d  = s2_q;
      cnt_d    = '0;
      acc_rise = s2_q;
      fall_d   = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef HOLD_REPEAT_EN
  // rep_ph_q selects the initial delay (0) or the steady repeat period (1)
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_ph_q, rep_ph_d;
  logic        rep_hit;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_ph_d  = rep_ph_q;
    rep_hit   = 1'b0;
    if (acc_rise) begin
      rep_cnt_d = '0;
      rep_ph_d  = 1'b0;
    end else if (level_q && level_d) begin
      if (!rep_ph_q && rep_cnt_q == 16'(REP_DELAY - 1)) begin
        rep_hit   = 1'b1;
        rep_cnt_d = '0;
        rep_ph_d  = 1'b1;
      end else if (rep_ph_q && rep_cnt_q == 16'(REP_PERIOD - 1)) begin
        rep_hit   = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_ph_q  <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_ph_q  <= rep_ph_d;
    end
  end

  assign rise_d = acc_rise | rep_hit;
`else
  assign rise_d = acc_rise;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= in_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

module in_sync_pulse #(
  parameter int CH         = 4,
  parameter int DB_CNT     = 4,
  parameter int REP_DELAY  = 50,
  parameter int REP_PERIOD = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] level,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);
  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("in_sync_pulse: CH out of range");
  end
  if (DB_CNT < 1 || DB_CNT > 65535) begin : g_bad_db
    $error("in_sync_pulse: DB_CNT out of range");
  end
  if (REP_DELAY < 1 || REP_DELAY > 65535 || REP_PERIOD < 1 || REP_PERIOD > 65535) begin : g_bad_rep
    $error("in_sync_pulse: repeat timing out of range");
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    in_sync_pulse_ch #(
      .DB_CNT     (DB_CNT)
`ifdef HOLD_REPEAT_EN
      ,
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in_i    (in[g]),
      .level_o (level[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g])
    );
  end
endmodule

// File: tb/tb_in_sync_pulse.sv
// Directed bench for in_sync_pulse (CH=4, DB_CNT=4, REP_DELAY=50, REP_PERIOD=10).
module tb_in_sync_pulse;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_r;
  logic [3:0] level, rise, fall;
  int         n_chk  = 0;
  int         n_pass = 0;

  in_sync_pulse #(.CH(4), .DB_CNT(4), .REP_DELAY(50), .REP_PERIOD(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_r),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    in_r = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int npulse;
    int exp_r;
    rst  = 1'b1;
    in_r = '0;
    repeat (3) tick();
    chk("rst_level", level, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);

    // single channel rise: accepted at edge 6
    do_reset();
    in_r = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_pre_level", level, 0);
    end
    tick();
    chk("t1_level6", level, 4'b0001);
    chk("t1_rise6", rise, 4'b0001);
    chk("t1_fall6", fall, 0);
    tick();
    chk("t1_rise7", rise, 0);
    chk("t1_level7", level, 4'b0001);

    // 3-cycle glitch on channel 1 is rejected
    do_reset();
    in_r = 4'b0010;
    repeat (3) tick();
    in_r = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t2_glitch", {level[1], rise[1], fall[1]}, 0);
    end

    // simultaneous rise on ch0/ch3, later fall on ch0
    do_reset();
    in_r = 4'b1001;
    repeat (6) tick();
    chk("t3_rise", rise, 4'b1001);
    chk("t3_level", level, 4'b1001);
    repeat (94) tick();
    in_r = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t3_fall_pre", fall, 0);
    end
    tick();
    chk("t3_fall", fall, 4'b0001);
    chk("t3_level_after", level, 4'b1000);
    chk("t3_rise0_at_fall", rise[0], 0);

    // reset mid-count abandons the pending rise
    do_reset();
    in_r = 4'b0100;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t4_rst_level", level, 0);
    chk("t4_rst_rise", rise, 0);
    chk("t4_rst_fall", fall, 0);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t4_pre_rise", rise, 0);
    end
    tick();
    chk("t4_rise", rise, 4'b0100);
    chk("t4_level", level, 4'b0100);

    // hold for 100 cycles past acceptance, level falls exactly at +100
    do_reset();
    in_r = 4'b0001;
    repeat (6) tick();
    chk("t5_acc_rise", rise[0], 1);
    npulse = 0;
    for (int k = 1; k <= 120; k++) begin
      tick();
`ifdef HOLD_REPEAT_EN
      exp_r = (k >= 50 && k < 100 && (k - 50) % 10 == 0) ? 1 : 0;
`else
      exp_r = 0;
`endif
      chk("t5_rep", rise[0], exp_r);
      chk("t5_excl", rise[0] & fall[0], 0);
      if (rise[0]) npulse++;
      if (k == 100) chk("t5_fall", fall[0], 1);
      if (k == 94) in_r = '0;
    end
`ifdef HOLD_REPEAT_EN
    chk("t5_npulse", npulse, 5);
`else
    chk("t5_npulse", npulse, 0);
`endif
    chk("t5_level_end", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
